// File: rtl/data_pipe.sv
// data_pipe: elastic pipeline register of DEPTH stages carrying a WIDTH-bit payload.
// Valid/ready handshake on both sides. Empty stages accept from upstream even while
// downstream is stalled, so bubbles collapse under backpressure. Outputs come straight
// from the last stage register, so there is no combinational in->out data path.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   flush      synchronous clear of all in-flight entries (payload registers untouched)
//   in_valid   producer has data on in_data
//   in_ready   pipe accepts in_data this cycle (combinational from out_ready)
//   in_data    input payload
//   out_valid  last stage holds a valid entry
//   out_ready  consumer takes out_data this cycle
//   out_data   output payload (last stage register)
//   count      number of valid stages, 0..DEPTH
module data_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    logic [DEPTH:0]   en;
    logic             push;
    logic [DEPTH-1:0] up_vld;
    logic [WIDTH-1:0] up_dat [DEPTH];

    // Enable ripples back from the consumer: a stage may load if it is empty or
    // the stage after it is moving.
    always_comb begin
        en[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            en[i] = !vld_q[i] || en[i+1];
        end
    end

    assign in_ready = en[0] && !flush;
    assign push     = in_valid && in_ready;

    always_comb begin
        up_vld[0] = push;
        up_dat[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld[i] = vld_q[i-1];
            up_dat[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= RESET_VALUE;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (en[i]) begin
                    vld_q[i] <= up_vld[i];
                    // A bubble moving in leaves the payload alone.
                    if (up_vld[i]) begin
                        dat_q[i] <= up_dat[i];
                    end
                end
            end
        end
    end

    // Popcount of stage valids; depends on registers only.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(vld_q[i]);
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: tb/tb_data_pipe.sv
// Self-checking bench for data_pipe: a DEPTH=4 instance and a DEPTH=1 instance, each
// with a scoreboard queue filled on input transfers and drained on output transfers.
module tb_data_pipe;

    typedef struct {
        logic [7:0] d;
        int         c;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [2:0] count;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] in_data1, out_data1;
    logic [0:0] count1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int pops1 = 0;
    bit lat_chk = 0;
    bit lat_chk1 = 0;
    ent_t q[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    data_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    data_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h5A)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .count(count1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes at the falling edge, advance one rising edge, then check counts.
    task automatic step();
        ent_t e;
        @(negedge clk);
        if (reset) begin
            if (out_valid && out_ready) begin
                check("pop_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    pops++;
                    check("out_data", out_data, e.d);
                    if (lat_chk) check("latency4", cyc - e.c, 4);
                end
            end
            if (in_valid && in_ready) q.push_back('{in_data, cyc});
            if (flush) q.delete();
            if (out_valid1 && out_ready1) begin
                check("pop1_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    pops1++;
                    check("out_data1", out_data1, e.d);
                    if (lat_chk1) check("latency1", cyc - e.c, 1);
                end
            end
            if (in_valid1 && in_ready1) q1.push_back('{in_data1, cyc});
            if (flush) q1.delete();
        end else begin
            q.delete();
            q1.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
        check("count", count, q.size());
        check("count1", count1, q1.size());
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        in_valid1 = 1'b1; in_data1 = 8'hAA; out_ready1 = 1'b0;

        // Reset held two cycles with input offered
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_count", count, 0);
        check("rst_out_data1", out_data1, 8'h5A);
        check("rst_out_valid1", out_valid1, 0);
        reset = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_in_ready1", in_ready1, 1);

        // Streaming, DEPTH=4
        out_ready = 1'b1; lat_chk = 1'b1; pops = 0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        lat_chk = 1'b0;
        check("stream_pops", pops, 8);
        check("stream_empty", out_valid, 0);

        // Backpressure fill
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h10 + 8'(i);
            step();
        end
        check("bp_full_count", count, 4);
        in_data = 8'h14;
        #1 check("bp_full_in_ready", in_ready, 0);
        step();
        check("bp_hold_count", count, 4);
        out_ready = 1'b1;
        #1 check("bp_pop_in_ready", in_ready, 1);
        step();
        check("bp_swap_count", count, 4);
        in_valid = 1'b0;
        repeat (5) step();
        check("bp_drained", count, 0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'hA0; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 8'hB0; step();
        in_valid = 1'b0; step(); step(); step();
        check("bub_count", count, 2);
        check("bub_vld", u_dut.vld_q, 4'b1100);
        check("bub_stage2", u_dut.dat_q[2], 8'hB0);
        check("bub_out_data", out_data, 8'hA0);
        out_ready = 1'b1;
        step();
        check("bub_second_valid", out_valid, 1);
        check("bub_second_data", out_data, 8'hB0);
        step();
        check("bub_empty", out_valid, 0);
        check("bub_keep_data", out_data, 8'hB0);

        // Flush with an input offered
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 8'hC0 + 8'(i);
            step();
        end
        check("fl_count3", count, 3);
        flush = 1'b1; in_data = 8'h55;
        #1 check("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_count", count, 0);
        check("fl_out_valid", out_valid, 0);
        out_ready = 1'b1;
        repeat (5) step();
        check("fl_no_output", out_valid, 0);

        // Reset mid-stream on a full pipe
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hD0 + 8'(i);
            step();
        end
        check("mr_full", count, 4);
        reset = 1'b0; out_ready = 1'b1; in_data = 8'h77;
        step();
        reset = 1'b1; in_valid = 1'b0;
        check("mr_count", count, 0);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_data", out_data, 8'h00);

        // DEPTH=1 streaming
        out_ready1 = 1'b1; lat_chk1 = 1'b1; pops1 = 0;
        for (int i = 1; i <= 6; i++) begin
            in_valid1 = 1'b1; in_data1 = 8'h20 + 8'(i);
            step();
        end
        in_valid1 = 1'b0;
        repeat (2) step();
        lat_chk1 = 1'b0;
        check("d1_pops", pops1, 6);

        // DEPTH=1 backpressure and simultaneous pop/push
        out_ready1 = 1'b0; in_valid1 = 1'b1; in_data1 = 8'h30;
        step();
        in_data1 = 8'h31;
        #1 check("d1_full_in_ready", in_ready1, 0);
        step();
        out_ready1 = 1'b1;
        #1 check("d1_pop_in_ready", in_ready1, 1);
        step();
        check("d1_swap_data", out_data1, 8'h31);
        in_valid1 = 1'b0;
        step(); step();
        check("d1_empty", out_valid1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_pipe.md
Name: data_pipe

Overview:
- Parametrised elastic pipeline register. It is the successor to the single-stage reset/load data register.
- Carries a WIDTH-bit payload through DEPTH register stages.
- Uses a valid/ready handshake on both sides, bubble-collapsing stall logic, a synchronous flush and an occupancy count.
- Sits between any producer/consumer pair in the datapath that needs retiming with backpressure.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VALUE, 0, value loaded into every data stage on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
- flush  input  1  synchronous clear of all in-flight entries.
- in_valid  input  1  producer has data on in_data.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  WIDTH  input payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  output payload (last stage register).
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- Stage state:
  - Each stage i (0..DEPTH-1) holds vld[i] and dat[i].
  - Stage DEPTH-1 drives out_valid/out_data directly. Outputs are registered only; there is no combinational in->out path.
- Reset (reset==0 at a rising edge): all vld <= 0, all dat <= RESET_VALUE. After reset: out_valid=0, out_data=RESET_VALUE, count=0, in_ready=1.
- Enable chain (combinational):
  - en[DEPTH] = out_ready; en[i] = !vld[i] || en[i+1].
  - in_ready = en[0] && !flush.
  - out_ready -> in_ready is a documented combinational path.
- Stage update when en[i]=1:
  - vld[i] <= upstream valid, where upstream is in_valid&&in_ready for i=0 and vld[i-1] for i>0.
  - dat[i] <= upstream data only if upstream valid=1; otherwise dat[i] holds.
  - Stages with en[i]=0 hold vld and dat.
- Bubble collapse: an empty stage accepts from upstream even when downstream is stalled, so gaps close under backpressure.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - in_data is ignored when no input transfer occurs.
- Latency: with out_ready held 1, an item accepted in cycle t presents out_valid=1 in cycle t+DEPTH. Sustained throughput is 1 item/cycle.
- Full: all vld=1 and out_ready=0 -> in_ready=0, count=DEPTH, nothing moves.
- Full with out_ready=1: in_ready=1, so simultaneous pop and push is allowed and count is unchanged.
- Empty: out_valid=0, count=0. out_data holds the last delivered value and is not cleared.
- count:
  - Popcount of vld, registered-derived with no input combinational dependency.
  - Changes by +1 (push only), -1 (pop only) or 0 (both or neither).
- Flush:
  - flush=1 at an edge -> all vld <= 0. dat is untouched.
  - in_ready=0 that cycle, so no input is accepted.
  - An output transfer in the same cycle still counts as consumed by the consumer.
- Priority: reset > flush > normal operation.
- Reset mid-stream discards all entries in one cycle, regardless of flush/in_valid/out_ready.
- Ordering: strict FIFO order. Entries are never duplicated or dropped except by flush/reset.
- DEPTH=1: a single stage. in_ready = !vld[0] || out_ready.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=8'hAA -> out_valid=0, out_data=8'h00, count=0; in_ready=1 after release.
- Streaming: DEPTH=4, out_ready=1, push 8'h01..8'h08 on consecutive cycles from cycle t -> out_data=8'h01 with out_valid at t+4, then 8'h02..8'h08 on consecutive cycles, no bubbles.
- Backpressure fill: out_ready=0, push 5 items -> first 4 accepted, count=4, in_ready=0 on the 5th. Raise out_ready -> 5th is accepted the same cycle as the first pop, count stays 4.
- Bubble collapse: push A, idle 2 cycles, push B with out_ready=0 -> A in stage 3 and B in stage 2 after settling, count=2. Release out_ready -> A then B on consecutive cycles.
- Flush: 3 entries held, assert flush 1 cycle with in_valid=1, in_data=8'h55 -> next cycle count=0, out_valid=0, and 8'h55 never appears at the output.
- Reset mid-operation plus DEPTH=1 build: pipe full, reset=0 for one cycle with flush=0 and out_ready=1 -> count=0, out_data=RESET_VALUE. Repeat streaming with DEPTH=1 -> latency 1, throughput 1/cycle.
